// File: rtl/hazard_pkg.sv
// Shared types for the decode->execute issue/hazard controller.
// Latency: none (types, limits and a helper function only).
// Backpressure: not applicable.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      DRAIN = 2'd2
   } hz_state_e;

   // One in-flight destination: valid marks a real instruction, rd its target.
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
   } inflight_t;

   localparam int MAX_DEPTH = 7;

   // One-hot of the destination for a live entry; x0 never counts as pending.
   function automatic logic [31:0] rd_onehot(input inflight_t e);
      logic [31:0] oh;
      oh = '0;
      if (e.valid && (e.rd != 5'd0)) begin
         oh[e.rd] = 1'b1;
      end
      return oh;
   endfunction

endpackage

// File: rtl/inflight_pipe.sv
// In-flight destination shift register, stage 0 = execute output.
// Latency: one stage per rising edge; last stage retires on the next shift.
// Backpressure: freeze_in holds every stage; kill0_in drops stage 0 regardless.
module inflight_pipe
   import hazard_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic                    req,
   input  logic                    reset,
   input  logic                    freeze_in,
   input  logic                    kill0_in,
   input  logic                    load_in,
   input  inflight_t               load_ent_in,
   output inflight_t [DEPTH-1:0]   ent_out
);

   inflight_t [DEPTH-1:0] ent_q;
   inflight_t [DEPTH-1:0] ent_d;

   // Next pipe contents: kill the stage-0 entry (it must not shift onward),
   // otherwise shift/load unless frozen by a multicycle op.
   always_comb begin
      ent_d = ent_q;
      if (kill0_in) begin
         ent_d[0] = '0;
      end else if (!freeze_in) begin
         ent_d[0] = load_in ? load_ent_in : '0;
      end
      for (int i = 1; i < DEPTH; i++) begin
         if (!freeze_in) begin
            ent_d[i] = (i == 1 && kill0_in) ? '0 : ent_q[i-1];
         end
      end
   end

   // Pipe registers with synchronous active-low clear.
   always_ff @(posedge req) begin
      if (!reset) begin
         ent_q <= '0;
      end else begin
         ent_q <= ent_d;
      end
   end

   assign ent_out = ent_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Issue/hazard controller: release, forward from execute, or bubble decode.
// Latency: stall/issue/fwd combinational; pipe, FSM and counter update per edge.
// Backpressure: stall_out holds decode and feeds a bubble into execute.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int DEPTH  = 3,
   parameter bit FWD_EN = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic             req,
   input  logic             reset,
   input  logic             issue_valid_in,
   input  logic [4:0]       rs1_in,
   input  logic [4:0]       rs2_in,
   input  logic             rs1_read_in,
   input  logic             rs2_read_in,
   input  logic [4:0]       rd_in,
   input  logic             rd_write_in,
   input  logic             mc_busy_in,
   input  logic             flush_in,
   output logic             stall_out,
   output logic             issue_out,
   output logic             fwd1_out,
   output logic             fwd2_out,
   output logic [31:0]      pending_out,
   output logic [1:0]       state_out,
   output logic [CNT_W-1:0] stall_cnt_out
);

   // Depth clamped to the legal range so an out-of-range override still builds.
   localparam int D = (DEPTH > MAX_DEPTH) ? MAX_DEPTH : ((DEPTH < 1) ? 1 : DEPTH);

   localparam logic [1:0] ST_RUN   = RUN;
   localparam logic [1:0] ST_STALL = STALL;
   localparam logic [1:0] ST_DRAIN = DRAIN;

   inflight_t [D-1:0] ent;
   inflight_t         load_ent;
   logic [1:0]        m1, m2;
   logic              hz1, hz2, hazard;
   logic [31:0]       pending;
   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // {match, youngest match is stage 0}; scanning oldest->youngest lets the
   // youngest hit overwrite older ones.
   function automatic logic [1:0] src_match(input logic rd_vld, input logic [4:0] rs,
                                            input inflight_t [D-1:0] ents);
      logic [1:0] r;
      r = 2'b00;
      for (int i = D - 1; i >= 0; i--) begin
         if (rd_vld && (rs != 5'd0) && ents[i].valid && (ents[i].rd == rs)) begin
            r = {1'b1, (i == 0)};
         end
      end
      return r;
   endfunction

   assign load_ent = '{valid: rd_write_in, rd: rd_in};

   inflight_pipe #(
      .DEPTH (D)
   ) u_pipe (
      .req         (req),
      .reset       (reset),
      .freeze_in   (mc_busy_in),
      .kill0_in    (flush_in),
      .load_in     (issue_out),
      .load_ent_in (load_ent),
      .ent_out     (ent)
   );

   // Source matching, forward selection and combined hazard.
   always_comb begin
      m1       = src_match(rs1_read_in, rs1_in, ent);
      m2       = src_match(rs2_read_in, rs2_in, ent);
      fwd1_out = FWD_EN && m1[1] && m1[0];
      fwd2_out = FWD_EN && m2[1] && m2[0];
      hz1      = m1[1] && !fwd1_out;
      hz2      = m2[1] && !fwd2_out;
      hazard   = hz1 || hz2;
   end

   // Pending-write bitmap over all live entries.
   always_comb begin
      pending = '0;
      for (int i = 0; i < D; i++) begin
         pending = pending | rd_onehot(ent[i]);
      end
   end

   assign stall_out   = (issue_valid_in && (hazard || mc_busy_in)) ||
                        (state_q == ST_DRAIN) || flush_in;
   assign issue_out   = issue_valid_in && !stall_out;
   assign pending_out = pending;
   assign state_out   = state_q;
   assign stall_cnt_out = cnt_q;

   // FSM next state: flush always drains one cycle; stall lasts until hazard clears.
   always_comb begin
      state_d = state_q;
      if (flush_in) begin
         state_d = ST_DRAIN;
      end else begin
         case (state_q)
            ST_RUN:   if (issue_valid_in && hazard) state_d = ST_STALL;
            ST_STALL: if (!hazard) state_d = ST_RUN;
            ST_DRAIN: state_d = ST_RUN;
            default:  state_d = ST_RUN;
         endcase
      end
   end

   // Saturating stall-cycle counter.
   always_comb begin
      cnt_d = cnt_q;
      if (stall_out && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State and counter registers with synchronous active-low clear.
   always_ff @(posedge req) begin
      if (!reset) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: directed table + hand sequences + random vs reference model.
// Two instances: forwarding (16-bit counter) and non-forwarding (4-bit counter).
// Outputs sampled on the falling edge, inputs driven 1 time unit after rising.
module tb_hazard_ctrl;

   localparam int DEPTH = 3;

   logic        req, reset;
   logic        issue_valid_in, rs1_read_in, rs2_read_in, rd_write_in, mc_busy_in, flush_in;
   logic [4:0]  rs1_in, rs2_in, rd_in;

   logic        f_stall, f_issue, f_fwd1, f_fwd2;
   logic [31:0] f_pend;
   logic [1:0]  f_state;
   logic [15:0] f_cnt;
   logic        n_stall, n_issue, n_fwd1, n_fwd2;
   logic [31:0] n_pend;
   logic [1:0]  n_state;
   logic [3:0]  n_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   hazard_ctrl #(.DEPTH(DEPTH), .FWD_EN(1'b1), .CNT_W(16)) dut_f (
      .req(req), .reset(reset), .issue_valid_in(issue_valid_in),
      .rs1_in(rs1_in), .rs2_in(rs2_in), .rs1_read_in(rs1_read_in), .rs2_read_in(rs2_read_in),
      .rd_in(rd_in), .rd_write_in(rd_write_in), .mc_busy_in(mc_busy_in), .flush_in(flush_in),
      .stall_out(f_stall), .issue_out(f_issue), .fwd1_out(f_fwd1), .fwd2_out(f_fwd2),
      .pending_out(f_pend), .state_out(f_state), .stall_cnt_out(f_cnt));

   hazard_ctrl #(.DEPTH(DEPTH), .FWD_EN(1'b0), .CNT_W(4)) dut_n (
      .req(req), .reset(reset), .issue_valid_in(issue_valid_in),
      .rs1_in(rs1_in), .rs2_in(rs2_in), .rs1_read_in(rs1_read_in), .rs2_read_in(rs2_read_in),
      .rd_in(rd_in), .rd_write_in(rd_write_in), .mc_busy_in(mc_busy_in), .flush_in(flush_in),
      .stall_out(n_stall), .issue_out(n_issue), .fwd1_out(n_fwd1), .fwd2_out(n_fwd2),
      .pending_out(n_pend), .state_out(n_state), .stall_cnt_out(n_cnt));

   initial begin
      req = 1'b0;
      forever #5 req = ~req;
   end

   // ---------------- reference model: list of in-flight writes with ages ----------------
   typedef struct {
      int         m;
      logic [4:0] rd;
      int         age;
   } flight_t;

   flight_t     fl[$];
   int          mst[2];
   int          mcnt[2];
   int          mmax[2];
   bit          mfwd[2];
   logic        o_stall[2], o_issue[2], o_f1[2], o_f2[2], o_hz[2];
   logic [31:0] o_pend[2];

   task automatic model_eval();
      for (int m = 0; m < 2; m++) begin
         int   y1, y2;
         logic f1, f2;
         y1 = 99;
         y2 = 99;
         o_pend[m] = '0;
         foreach (fl[j]) begin
            if (fl[j].m == m) begin
               o_pend[m][fl[j].rd] = 1'b1;
               if (rs1_read_in && rs1_in != 0 && fl[j].rd == rs1_in && fl[j].age < y1) y1 = fl[j].age;
               if (rs2_read_in && rs2_in != 0 && fl[j].rd == rs2_in && fl[j].age < y2) y2 = fl[j].age;
            end
         end
         f1 = mfwd[m] && (y1 == 0);
         f2 = mfwd[m] && (y2 == 0);
         o_f1[m]    = f1;
         o_f2[m]    = f2;
         o_hz[m]    = ((y1 != 99) && !f1) || ((y2 != 99) && !f2);
         o_stall[m] = (issue_valid_in && (o_hz[m] || mc_busy_in)) || (mst[m] == 2) || flush_in;
         o_issue[m] = issue_valid_in && !o_stall[m];
      end
   endtask

   task automatic model_adv();
      flight_t nq[$];
      flight_t e;
      for (int m = 0; m < 2; m++) begin
         if (!reset) begin
            mst[m]  = 0;
            mcnt[m] = 0;
         end else begin
            if (flush_in)          mst[m] = 2;
            else if (mst[m] == 0)  mst[m] = (issue_valid_in && o_hz[m]) ? 1 : 0;
            else if (mst[m] == 1)  mst[m] = o_hz[m] ? 1 : 0;
            else                   mst[m] = 0;
            if (o_stall[m] && mcnt[m] < mmax[m]) mcnt[m]++;
         end
      end
      if (reset) begin
         foreach (fl[j]) begin
            e = fl[j];
            if (!(flush_in && e.age == 0)) begin
               if (!mc_busy_in) e.age++;
               if (e.age < DEPTH) nq.push_back(e);
            end
         end
         for (int m = 0; m < 2; m++) begin
            if (o_issue[m] && rd_write_in && rd_in != 0) begin
               e.m = m; e.rd = rd_in; e.age = 0;
               nq.push_back(e);
            end
         end
      end
      fl = nq;
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic set_in(input logic iv, input logic [4:0] r1, input logic rd1, input logic [4:0] r2,
                         input logic rd2, input logic [4:0] rd, input logic wr, input logic busy,
                         input logic fl_i, input logic rst);
      issue_valid_in = iv; rs1_in = r1; rs1_read_in = rd1; rs2_in = r2; rs2_read_in = rd2;
      rd_in = rd; rd_write_in = wr; mc_busy_in = busy; flush_in = fl_i; reset = rst;
   endtask

   task automatic cyc_sample();
      @(negedge req);
      model_eval();
   endtask

   task automatic cyc_end();
      model_adv();
      @(posedge req);
      #1;
   endtask

   // ---------------- directed table (forwarding instance, DEPTH=3) ----------------
   typedef struct {
      logic        iv, r1, r2, wr, busy, fl, rst;
      logic [4:0]  rs1, rs2, rd;
      logic        e_stall, e_issue, e_f1, e_f2;
      logic [31:0] e_pend;
      logic [1:0]  e_state;
      logic [15:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic iv, input logic [4:0] rs1, input logic r1,
                               input logic [4:0] rs2, input logic r2, input logic [4:0] rd,
                               input logic wr, input logic busy, input logic fl, input logic rst,
                               input logic es, input logic ei, input logic ef1, input logic ef2,
                               input logic [31:0] ep, input logic [1:0] est, input logic [15:0] ec);
      vec_t v;
      v.iv = iv; v.rs1 = rs1; v.r1 = r1; v.rs2 = rs2; v.r2 = r2; v.rd = rd; v.wr = wr;
      v.busy = busy; v.fl = fl; v.rst = rst;
      v.e_stall = es; v.e_issue = ei; v.e_f1 = ef1; v.e_f2 = ef2;
      v.e_pend = ep; v.e_state = est; v.e_cnt = ec;
      return v;
   endfunction

   vec_t tv[26];

   initial begin
      mmax[0] = 65535; mmax[1] = 15;
      mfwd[0] = 1'b1;  mfwd[1] = 1'b0;
      mst[0] = 0; mst[1] = 0; mcnt[0] = 0; mcnt[1] = 0;

      //          iv rs1 r1 rs2 r2 rd  wr bz fl rst | st is f1 f2 pend      state cnt
      tv[0]  = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 1,   0, 0, 0, 0, 32'h0,    0,    0);
      tv[1]  = mk(1, 1,  1, 0,  0, 1,  1, 0, 0, 1,   0, 1, 0, 0, 32'h0,    0,    0);
      tv[2]  = mk(1, 3,  1, 4,  1, 2,  1, 0, 0, 1,   0, 1, 0, 0, 32'h2,    0,    0);
      tv[3]  = mk(1, 2,  1, 2,  1, 7,  1, 0, 0, 1,   0, 1, 1, 1, 32'h6,    0,    0);
      tv[4]  = mk(1, 0,  1, 0,  0, 0,  1, 0, 0, 1,   0, 1, 0, 0, 32'h86,   0,    0);
      tv[5]  = mk(1, 0,  1, 0,  1, 5,  1, 0, 0, 1,   0, 1, 0, 0, 32'h84,   0,    0);
      tv[6]  = mk(1, 7,  1, 0,  1, 8,  1, 0, 0, 1,   1, 0, 0, 0, 32'hA0,   0,    0);
      tv[7]  = mk(1, 7,  1, 0,  1, 8,  1, 0, 0, 1,   0, 1, 0, 0, 32'h20,   1,    1);
      tv[8]  = mk(1, 0,  0, 0,  0, 10, 1, 0, 0, 1,   0, 1, 0, 0, 32'h120,  0,    1);
      tv[9]  = mk(1, 0,  0, 0,  0, 9,  1, 0, 0, 1,   0, 1, 0, 0, 32'h500,  0,    1);
      tv[10] = mk(1, 9,  1, 0,  1, 11, 1, 0, 1, 1,   1, 0, 1, 0, 32'h700,  0,    1);
      tv[11] = mk(1, 9,  1, 0,  1, 11, 1, 0, 0, 1,   1, 0, 0, 0, 32'h400,  2,    2);
      tv[12] = mk(1, 9,  1, 0,  1, 11, 1, 0, 0, 1,   0, 1, 0, 0, 32'h0,    0,    3);
      tv[13] = mk(1, 0,  0, 0,  0, 7,  1, 0, 0, 1,   0, 1, 0, 0, 32'h800,  0,    3);
      tv[14] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 1,   0, 0, 0, 0, 32'h880,  0,    3);
      tv[15] = mk(1, 7,  1, 0,  1, 12, 1, 1, 0, 1,   1, 0, 0, 0, 32'h880,  0,    3);
      tv[16] = mk(1, 7,  1, 0,  1, 12, 1, 1, 0, 1,   1, 0, 0, 0, 32'h880,  1,    4);
      tv[17] = mk(1, 7,  1, 0,  1, 12, 1, 1, 0, 1,   1, 0, 0, 0, 32'h880,  1,    5);
      tv[18] = mk(1, 7,  1, 0,  1, 12, 1, 1, 0, 1,   1, 0, 0, 0, 32'h880,  1,    6);
      tv[19] = mk(1, 7,  1, 0,  1, 12, 1, 0, 0, 1,   1, 0, 0, 0, 32'h880,  1,    7);
      tv[20] = mk(1, 7,  1, 0,  1, 12, 1, 0, 0, 1,   1, 0, 0, 0, 32'h80,   1,    8);
      tv[21] = mk(1, 7,  1, 0,  1, 12, 1, 0, 0, 1,   0, 1, 0, 0, 32'h0,    1,    9);
      tv[22] = mk(0, 0,  0, 0,  0, 0,  0, 0, 0, 1,   0, 0, 0, 0, 32'h1000, 0,    9);
      tv[23] = mk(1, 12, 1, 0,  1, 13, 1, 0, 0, 1,   1, 0, 0, 0, 32'h1000, 0,    9);
      tv[24] = mk(1, 12, 1, 0,  1, 13, 1, 0, 0, 0,   1, 0, 0, 0, 32'h1000, 1,    10);
      tv[25] = mk(1, 12, 1, 0,  1, 13, 1, 0, 0, 1,   0, 1, 0, 0, 32'h0,    0,    0);

      // Initial synchronous reset.
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge req);
      #1;

      for (int i = 0; i < 26; i++) begin
         set_in(tv[i].iv, tv[i].rs1, tv[i].r1, tv[i].rs2, tv[i].r2, tv[i].rd, tv[i].wr,
                tv[i].busy, tv[i].fl, tv[i].rst);
         cyc_sample();
         chk($sformatf("v%0d stall", i), {31'd0, f_stall}, {31'd0, tv[i].e_stall});
         chk($sformatf("v%0d issue", i), {31'd0, f_issue}, {31'd0, tv[i].e_issue});
         chk($sformatf("v%0d fwd1", i),  {31'd0, f_fwd1},  {31'd0, tv[i].e_f1});
         chk($sformatf("v%0d fwd2", i),  {31'd0, f_fwd2},  {31'd0, tv[i].e_f2});
         chk($sformatf("v%0d pending", i), f_pend, tv[i].e_pend);
         chk($sformatf("v%0d state", i), {30'd0, f_state}, {30'd0, tv[i].e_state});
         chk($sformatf("v%0d cnt", i),   {16'd0, f_cnt},   {16'd0, tv[i].e_cnt});
         cyc_end();
      end

      // ---------- no forwarding: RAW distance 1 costs DEPTH bubbles ----------
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc_sample(); cyc_end();
      set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 1);              // addi x1
      cyc_sample();
      chk("nofwd producer issue", {31'd0, n_issue}, 32'd1);
      chk("nofwd cnt start", {28'd0, n_cnt}, 32'd0);
      cyc_end();
      set_in(1, 1, 1, 1, 1, 2, 1, 0, 0, 1);              // add x2,x1,x1
      for (int k = 0; k < 4; k++) begin
         cyc_sample();
         chk($sformatf("nofwd stall c%0d", k), {31'd0, n_stall}, (k < DEPTH) ? 32'd1 : 32'd0);
         chk($sformatf("nofwd issue c%0d", k), {31'd0, n_issue}, (k < DEPTH) ? 32'd0 : 32'd1);
         chk($sformatf("nofwd fwd1 c%0d", k),  {31'd0, n_fwd1},  32'd0);
         if (k == 0) begin
            chk("fwd inst fwd1", {31'd0, f_fwd1}, 32'd1);
            chk("fwd inst fwd2", {31'd0, f_fwd2}, 32'd1);
            chk("fwd inst stall", {31'd0, f_stall}, 32'd0);
         end
         if (k == DEPTH) chk("nofwd cnt after RAW", {28'd0, n_cnt}, 32'd3);
         cyc_end();
      end

      // ---------- counter saturation on the 4-bit instance ----------
      set_in(1, 0, 0, 0, 0, 3, 1, 1, 0, 1);
      repeat (16) begin
         cyc_sample(); cyc_end();
      end
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc_sample();
      chk("nofwd cnt saturated", {28'd0, n_cnt}, 32'hF);
      chk("fwd cnt model", {16'd0, f_cnt}, mcnt[0]);
      cyc_end();

      // ---------- randomized run vs reference model ----------
      for (int c = 0; c < 3000; c++) begin
         set_in($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), $urandom_range(0, 9) < 7,
                5'($urandom_range(0, 7)), $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)),
                $urandom_range(0, 9) < 9, $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0,
                $urandom_range(0, 199) != 0);
         cyc_sample();
         chk($sformatf("rnd%0d f stall", c), {31'd0, f_stall}, {31'd0, o_stall[0]});
         chk($sformatf("rnd%0d f issue", c), {31'd0, f_issue}, {31'd0, o_issue[0]});
         chk($sformatf("rnd%0d f fwd", c),   {30'd0, f_fwd1, f_fwd2}, {30'd0, o_f1[0], o_f2[0]});
         chk($sformatf("rnd%0d f pend", c),  f_pend, o_pend[0]);
         chk($sformatf("rnd%0d f state", c), {30'd0, f_state}, mst[0]);
         chk($sformatf("rnd%0d f cnt", c),   {16'd0, f_cnt}, mcnt[0]);
         chk($sformatf("rnd%0d n stall", c), {31'd0, n_stall}, {31'd0, o_stall[1]});
         chk($sformatf("rnd%0d n issue", c), {31'd0, n_issue}, {31'd0, o_issue[1]});
         chk($sformatf("rnd%0d n fwd", c),   {30'd0, n_fwd1, n_fwd2}, {30'd0, o_f1[1], o_f2[1]});
         chk($sformatf("rnd%0d n pend", c),  n_pend, o_pend[1]);
         chk($sformatf("rnd%0d n state", c), {30'd0, n_state}, mst[1]);
         chk($sformatf("rnd%0d n cnt", c),   {28'd0, n_cnt}, mcnt[1]);
         cyc_end();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Issue/hazard controller that sequences the decode→execute pipeline. It compares decode's unregistered source registers against destinations still in flight, and either releases the instruction, selects a forward from the execute result, or inserts a bubble. It sits beside `decode` and `execute`. Its `stall_out` drives decode's hold and execute's `stall_in`, replacing the direct `~valid_out` tie.

## Interface
- `DEPTH`, 3, stages from issue to register-file write (legal 1..7); stage 0 = execute output
- `FWD_EN`, 1, 1 = a hazard whose youngest match is stage 0 forwards instead of stalling
- `CNT_W`, 16, width of stall performance counter
- `req` in 1: clock, rising edge
- `reset` in 1: synchronous, active-low
- `issue_valid_in` in 1: decode holds a valid instruction
- `rs1_in`, `rs2_in` in 5: decode source registers (unregistered)
- `rs1_read_in`, `rs2_read_in` in 1: source actually read
- `rd_in` in 5, `rd_write_in` in 1: destination of the decode instruction
- `mc_busy_in` in 1: execute multicycle op busy; freezes pipe
- `flush_in` in 1: branch/redirect kill
- `stall_out` out 1: hold decode, bubble into execute
- `issue_out` out 1: instruction accepted this cycle
- `fwd1_out`, `fwd2_out` out 1: 1 = take operand from execute result
- `pending_out` out 32: bitmap of registers with in-flight writes (bit 0 always 0)
- `state_out` out 2: FSM state
- `stall_cnt_out` out CNT_W: saturating count of stall cycles

## Operation
- In-flight pipe: DEPTH entries {valid, rd}. It shifts one stage per edge unless `mc_busy_in` = 1. The entry leaving stage DEPTH-1 retires.
- An entry is live when `valid` = 1 and `rd` ≠ 0. `pending_out` = OR of one-hot(rd) over live entries.
- Match for source k: `rsk_read_in` = 1, `rsk_in` ≠ 0, and `rsk_in` equals a live entry's rd. The youngest (lowest-index) match decides.
- Source k hazard = match exists AND NOT (`FWD_EN` AND youngest match is stage 0). `fwdk_out` = `FWD_EN` AND youngest match at stage 0.
- FSM states: RUN=0, STALL=1, DRAIN=2.
  - RUN→STALL: on hazard with `issue_valid_in`.
  - STALL→RUN: first cycle with no hazard.
  - Any state→DRAIN: on `flush_in`.
  - DRAIN→RUN: after exactly 1 cycle.
- `stall_out` = (`issue_valid_in` AND (hazard OR `mc_busy_in`)) OR state==DRAIN OR `flush_in`.
- `issue_out` = `issue_valid_in` AND NOT `stall_out`. On issue, stage 0 loads {`rd_write_in`, `rd_in`}. Otherwise stage 0 loads a bubble, unless the pipe is frozen.
- Flush: the stage-0 entry is invalidated at the next edge; stages ≥1 are kept, since they are older and committed.
- `flush_in` with `mc_busy_in`: flush wins for stage 0; the rest stay frozen.
- `stall_cnt_out` increments on every cycle with `stall_out` = 1 and saturates at all-ones.

## Timing
- `stall_out`, `issue_out`, and `fwdk_out` are combinational from the inputs and the registered pipe, valid in the same cycle as decode's unregistered outputs.
- Pipe, FSM, and counter update on rising `req`.
- Issue→`pending_out` set: 1 cycle. Clear: DEPTH cycles after issue, plus cycles frozen by `mc_busy_in`.
- Back-to-back dependent ops:
  - `FWD_EN`=1: 0 bubbles.
  - `FWD_EN`=0: DEPTH bubbles.
- Reset (`reset` = 0 at an edge): all entries invalid, state RUN, counter 0.
- Reset-state outputs: `stall_out` = 0 unless busy, `pending_out` = 0, `fwd*` = 0, `state_out` = 0. Reset mid-stall discards all entries.
- Simultaneous issue and retire of the same rd: the retiring entry no longer counts and the new entry is live. `pending_out` bit stays 1.

## Structure
- `hazard_pkg`:
  - `hz_state_e` {RUN, STALL, DRAIN}
  - `inflight_t` {logic valid; logic [4:0] rd}
  - `MAX_DEPTH` = 7
- Sub-module `inflight_pipe`: the DEPTH-entry shift register with freeze, stage-0 kill and load. It exports the entry array.
- Match/priority logic and the FSM live in `hazard_ctrl`.

## Test plan
- Independent ops: x1←x1+1 then x2←x3+x4, `FWD_EN`=1 → `issue_out` 1 both cycles, `stall_out` 0, `fwd*` 0.
- RAW distance 1:
  - `FWD_EN`=1: addi x1 then add x2,x1,x1 → `fwd1_out`=`fwd2_out`=1, no stall.
  - `FWD_EN`=0: 3 stall cycles, `stall_cnt_out`=3.
- Writes to x0: addi x0 then add x5,x0,x0 → no stall, `pending_out`=0.
- `mc_busy_in` high 4 cycles with x7 in stage 1 → pipe frozen, `pending_out`[7] held 4 extra cycles, dependent op stalls throughout.
- `flush_in` while x9 is in stage 0 and x10 in stage 1:
  - next cycle `pending_out`[9]=0 and [10]=1, `state_out`=DRAIN for 1 cycle;
  - a dependent instruction on x9 issues with no stall.
- `reset` low during STALL → next edge `pending_out`=0, `state_out`=RUN, `stall_cnt_out`=0, and the held instruction issues.
